if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues word fetches to instruction memory over a request/grant/response handshake. It delivers {pc_plus4, instruction, valid} in the form the IF/ID register latches, and honours the hazard unit's stall and the branch unit's redirect. At most one memory request is outstanding; a 1-entry hold buffer keeps a response that arrives during a stall.

---
 rtl/if_pkg.sv | 16 +
 rtl/if_fetch_unit_hold_buf.sv | 33 +++
 rtl/if_fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared states and constants for the instruction-fetch stage
package if_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_IDLE_ERR
    } state_t;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// rtl/if_fetch_unit_hold_buf.sv - fetch_hold_buf: 1-entry {pc_plus4, instr} parking register
module fetch_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o
);

    logic [31:0] pc_plus4_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_plus4_q <= 32'h0;
            instr_q    <= 32'h0;
        end else if (clear_i || unload_i) begin
            pc_plus4_q <= 32'h0;
            instr_q    <= 32'h0;
        end else if (load_i) begin
            pc_plus4_q <= pc_plus4_i;
            instr_q    <= instr_i;
        end
    end

    assign pc_plus4_o = pc_plus4_q;
    assign instr_o    = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC, single-outstanding imem fetch, hold buffer, redirect
// Optional misaligned-redirect trap enabled by FETCH_ALIGN_CHECK_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = if_pkg::RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = if_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus4,
    output logic [31:0] instruction,
    output logic        valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    import if_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic        buf_load, buf_unload, buf_clear;
    logic [31:0] buf_pc_plus4, buf_instr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
`endif

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load_i     (buf_load),
        .unload_i   (buf_unload),
        .clear_i    (buf_clear),
        .pc_plus4_i (req_pc_q + PC_INC),
        .instr_i    (imem_rdata),
        .pc_plus4_o (buf_pc_plus4),
        .instr_o    (buf_instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0;
            pc_plus4_q <= 32'h0;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        drop_d     = drop_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif

        // IF/ID consumes the slot on every unstalled edge; refill below overrides.
        if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_INC;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!stall) begin
                        instr_d    = imem_rdata;
                        pc_plus4_d = req_pc_q + PC_INC;
                        valid_d    = 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    instr_d    = buf_instr;
                    pc_plus4_d = buf_pc_plus4;
                    valid_d    = 1'b1;
                    buf_unload = 1'b1;
                    state_d    = S_REQ;
                end
            end
            // A response still in flight when the trap was taken retires the drop flag here.
            S_IDLE_ERR: begin
                if (imem_rvalid) drop_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d       = redirect_pc;
            pc_plus4_d = pc_plus4_q;
            valid_d    = 1'b0;
            instr_d    = NOP_WORD;
            buf_load   = 1'b0;
            buf_unload = 1'b0;
            buf_clear  = 1'b1;
            case (state_q)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = S_IDLE_ERR;
            end else begin
                misalign_d = 1'b0;
            end
`endif
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign instruction = instr_q;
    assign valid       = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and randomized checks of if_fetch_unit against a program-order model
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;
    logic        valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_plus4       (pc_plus4),
        .instruction    (instruction),
        .valid          (valid)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    int checks = 0;
    int errors = 0;
    int consumed = 0;

    // Memory responder state
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          lat_min, lat_max;
    bit          rand_gnt;

    // Program-order reference: address of the next instruction IF/ID should accept
    logic [31:0] exp_addr;

    // Previous-cycle observations for the per-cycle rules
    bit          p_known;
    logic        p_valid, p_stall, p_rd, p_req, p_gnt;
    logic [31:0] p_pc4, p_instr, p_addr, p_rpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        mem_pend = 1'b0;
        mem_delay = 0;
        mem_addr = 32'h0;
        p_known = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc4", pc_plus4, 32'h0);
        chk("rst_instr", instruction, NOP);
        reset = 1'b0;
        exp_addr = RST;
    endtask

    // One clock cycle: drive inputs, apply per-cycle rules and the program-order model, advance.
    task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc);
        stall = st;
        redirect_valid = rd;
        redirect_pc = rpc;
        imem_gnt = imem_req && (!rand_gnt || ($urandom_range(0, 1) == 1));
        imem_rvalid = mem_pend && (mem_delay == 0);
        imem_rdata = imem_rvalid ? mem_word(mem_addr) : $urandom;

        if (!valid) chk("nop_when_invalid", instruction, NOP);
        if (mem_pend) chk("single_outstanding", 32'(imem_req), 32'd0);
        if (p_known) begin
            if (p_stall && !p_rd) begin
                chk("stall_hold_valid", 32'(valid), 32'(p_valid));
                chk("stall_hold_pc4", pc_plus4, p_pc4);
                chk("stall_hold_instr", instruction, p_instr);
            end
            if (p_rd) chk("redirect_clears_valid", 32'(valid), 32'd0);
            if (p_req && !p_gnt) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_stable", imem_addr, p_rd ? p_rpc : p_addr);
            end
        end
        if (valid && !st && !rd) begin
            chk("order_pc4", pc_plus4, exp_addr + 32'd4);
            chk("order_instr", instruction, mem_word(exp_addr));
            exp_addr = exp_addr + 32'd4;
            consumed++;
        end
        if (rd) exp_addr = rpc;

        p_known = 1'b1;
        p_valid = valid;
        p_pc4 = pc_plus4;
        p_instr = instruction;
        p_stall = st;
        p_rd = rd;
        p_rpc = rpc;
        p_req = imem_req;
        p_gnt = imem_gnt;
        p_addr = imem_addr;

        @(posedge clk);
        #1;
        if (imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend) mem_delay--;
        if (imem_gnt) begin
            mem_pend = 1'b1;
            mem_addr = p_addr;
            mem_delay = int'($urandom_range(lat_max, lat_min)) - 1;
        end
    endtask

    initial begin
        rand_gnt = 1'b0;
        lat_min = 1;
        lat_max = 1;
        reset = 1'b1;
        do_reset();

        // Back-to-back fetch: grant always, response one cycle later
        cyc(0, 0, 0);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        cyc(0, 0, 0);
        chk("c2_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0);
        chk("c3_valid", 32'(valid), 32'd1);
        chk("c3_pc4", pc_plus4, 32'h4);
        chk("c3_instr", instruction, 32'hA5A5_0000);
        chk("c3_addr", imem_addr, 32'h4);
        cyc(0, 0, 0);
        chk("c4_valid", 32'(valid), 32'd0);
        cyc(0, 0, 0);
        chk("c5_valid", 32'(valid), 32'd1);
        chk("c5_pc4", pc_plus4, 32'h8);
        chk("c5_instr", instruction, 32'hA5A5_0004);
        chk("c5_addr", imem_addr, 32'h8);
        cyc(0, 0, 0);

        // Stall over the response for 0x8
        cyc(1, 0, 0);
        chk("hold_req0", 32'(imem_req), 32'd0);
        chk("hold_pc4", pc_plus4, 32'h8);
        cyc(1, 0, 0);
        chk("hold_req1", 32'(imem_req), 32'd0);
        cyc(1, 0, 0);
        chk("hold_req2", 32'(imem_req), 32'd0);
        chk("hold_valid", 32'(valid), 32'd0);
        cyc(0, 0, 0);
        chk("unhold_valid", 32'(valid), 32'd1);
        chk("unhold_pc4", pc_plus4, 32'hC);
        chk("unhold_instr", instruction, 32'hA5A5_0008);
        chk("unhold_next_addr", imem_addr, 32'hC);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // Redirect while waiting on 0x10; its late response must be dropped
        chk("c12_addr", imem_addr, 32'h10);
        lat_min = 2;
        lat_max = 2;
        cyc(0, 0, 0);
        chk("wait_req", 32'(imem_req), 32'd0);
        lat_min = 1;
        lat_max = 1;
        cyc(0, 1, 32'h100);
        chk("drop_valid", 32'(valid), 32'd0);
        chk("drop_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", 32'(valid), 32'd0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("redir_pc4", pc_plus4, 32'h104);
        chk("redir_instr", instruction, 32'hA5A5_0100);
        cyc(0, 0, 0);

        // Stall into S_HOLD, then redirect+stall: held word must vanish
        cyc(1, 0, 0);
        chk("hold2_req", 32'(imem_req), 32'd0);
        cyc(1, 1, 32'h200);
        chk("hr_valid", 32'(valid), 32'd0);
        chk("hr_req", 32'(imem_req), 32'd1);
        chk("hr_addr", imem_addr, 32'h200);
        cyc(0, 0, 0);
        chk("hr_valid2", 32'(valid), 32'd0);
        cyc(0, 0, 0);
        chk("hr_pc4", pc_plus4, 32'h204);
        chk("hr_instr", instruction, 32'hA5A5_0200);
        cyc(0, 0, 0);

        // Asynchronous reset in S_WAIT, followed by a stray response
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(valid), 32'd0);
        chk("areset_pc4", pc_plus4, 32'h0);
        chk("areset_instr", instruction, NOP);
        chk("areset_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_pend = 1'b0;
        p_known = 1'b0;
        exp_addr = RST;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RST);
        chk("post_rst_valid", 32'(valid), 32'd0);
        chk("post_rst_pc4", pc_plus4, 32'h0);
        chk("post_rst_instr", instruction, NOP);
        repeat (4) cyc(0, 0, 0);

`ifdef FETCH_ALIGN_CHECK_EN
        do_reset();
        cyc(0, 1, 32'h102);
        chk("mis_flag", 32'(fetch_misalign), 32'd1);
        chk("mis_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("mis_req2", 32'(imem_req), 32'd0);
        chk("mis_valid", 32'(valid), 32'd0);
        chk("mis_flag2", 32'(fetch_misalign), 32'd1);
        cyc(0, 1, 32'h200);
        chk("mis_clear", 32'(fetch_misalign), 32'd0);
        chk("mis_resume_req", 32'(imem_req), 32'd1);
        chk("mis_resume_addr", imem_addr, 32'h200);
        repeat (4) cyc(0, 0, 0);
`endif

        // Randomized grants, latencies, stalls and redirects
        do_reset();
        rand_gnt = 1'b1;
        lat_min = 1;
        lat_max = 3;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 12) == 0,
                $urandom & 32'h0000_FFFC);
        end
        chk("random_progress", 32'(consumed > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
